firebird7_ijtag_sib_multi: RTL
==============================

// Module: firebird7_ijtag_sib_multi
// PURPOSE
//  - N-way Segment Insertion Bit group for the IJTAG network: one scan bit per child segment, each opening/closing that segment.
//  - Chain order: si -> [seg0 if open] -> sib[0] -> [seg1 if open] -> sib[1] ... -> sib[N-1] -> retiming latch -> so.
//  - Replaces chains of single SIBs in gate/spare/redundancy hierarchies.
//  - Adds an optional exclusive-open rule and optional parity-protected update.
// PARAMETERS
//  - NUM_SEG      4  number of child segments / SIB bits (1..16)
//  - EXCLUSIVE    0  1: an update with more than one bit set is rejected
//  - CAPTURE_STAT 0  0: capture loads 0; 1: capture loads current update-latch value into each sib bit
// PORTS
//  - ijtag_tck      in   1        TCK; shift/capture on posedge, update/enable on negedge
//  - ijtag_reset    in   1        reset, asynchronous, active-low
//  - ijtag_sel      in   1        this SIB group is on the active path
//  - ijtag_ce/se/ue in   1        capture / shift / update enables
//  - ijtag_si       in   1        scan in
//  - ijtag_so       out  1        scan out, retimed
//  - ijtag_from_so  in   NUM_SEG  scan out of child segment i
//  - ijtag_to_si    out  NUM_SEG  scan in to child segment i
//  - ijtag_to_sel   out  NUM_SEG  select for child segment i
// BEHAVIOUR
//  - prev(i) = ijtag_si for i=0, else sib[i-1].
//  - Combinational outputs: to_si[i] = prev(i); to_sel[i] = en[i] & ijtag_sel.
//  - Posedge tck, when sel=1; capture has priority over shift:
//      ce: sib[i] <= CAPTURE_STAT ? lat[i] : 0
//      se: sib[i] <= lat[i] ? from_so[i] : prev(i)
//  - Negedge tck, when ue&sel=1 and the update is accepted: lat <= sib.
//  - Negedge tck, every cycle: en <= lat. Segment i therefore opens or closes one full tck cycle after the update edge.
//  - Update rejection: when EXCLUSIVE=1 and popcount(sib)>1, lat holds its old value.
//  - so: latch transparent while tck=0, driven from the last chain element (sib[N-1], or par when the parity feature is on).
//  - Chain length = NUM_SEG + sum of open segment lengths (+1 with parity).
//  - Async reset clears sib, lat, en, par and err. so goes to 0 on the next tck-low phase; to_sel = 0 immediately.
//  - Reset during shift aborts the shift; no partial update is ever applied.
//  - sel=0 freezes sib and lat. en keeps tracking lat. to_sel is forced to 0.
//  - ce and se asserted together: ce wins. ue in the same cycle as ce/se is legal; ue acts on negedge with the post-posedge sib.
// CONFIGURATION
//  - Macro FIREBIRD7_SIB_MULTI_PARITY_EN.
//  - Defined:
//      extra scan flop par follows sib[N-1] in the chain
//      capture loads par <= err (sticky error visible on readout)
//      update accepted only if ^{sib,par}==1 (odd parity) and the EXCLUSIVE rule passes
//      any rejected update sets sticky err; err is cleared only by ijtag_reset
//  - Undefined: no par flop, no err; so driven from sib[N-1]; only the EXCLUSIVE rule applies.
// STRUCTURE
//  - Package firebird7_ijtag_pkg:
//      FB7_SIB_MAX_SEG = 16
//      function fb7_onehot0(logic [15:0]) returning "at most one bit set"
//  - Sub-module firebird7_ijtag_sib_cell, instantiated NUM_SEG times:
//      contains the sib scan flop, update latch and enable flop
//      takes an external accept strobe for the update
//  - Top level holds the prev chaining, accept logic, parity/err and so retiming latch.
// TESTING
//  - Reset, then one Capture-DR with CAPTURE_STAT=0: shift out 4 bits -> 0000. Throughout, to_sel = 0000, so = 0.
//  - Open segment 2: shift in 0100, then update -> lat=0100. to_sel[2] rises one tck after the update negedge. Next chain length = 4+len(seg2), and data flows si->sib0->sib1->seg2->sib2->sib3.
//  - EXCLUSIVE=1, lat=0100: shift 0110, then update -> lat stays 0100 and to_sel is unchanged. Then shift 0001, update -> lat=0001.
//  - PARITY_EN, lat=0000: shift {sib=0011, par=0} (even), update -> rejected, err=1. Next capture reads par=1. Then shift {0011, par=1}, update -> lat=0011, err stays 1.
//  - Assert reset mid-shift while lat=1111 -> to_sel=0000 at once, lat=0000, err=0. After release, chain length = NUM_SEG (+1 with parity).
//  - sel=0 with ue and se pulsing for 10 cycles -> sib and lat unchanged, to_sel = 0000. Raising sel again restores to_sel = lat.

Source files
------------

// File: rtl/firebird7_ijtag_pkg.sv
// Shared constants and helpers for the firebird7 IJTAG segment-insertion blocks.
package firebird7_ijtag_pkg;

    localparam int FB7_SIB_MAX_SEG = 16;

    // True when at most one bit of v is set.
    function automatic logic fb7_onehot0(input logic [15:0] v);
        return (v & (v - 16'd1)) == 16'd0;
    endfunction

endpackage

// File: rtl/firebird7_ijtag_sib_cell.sv
// One SIB bit: scan flop (posedge), update latch and segment-enable flop (negedge).
// The update is taken only when the parent raises accept_i.
module firebird7_ijtag_sib_cell #(
    parameter int CAPTURE_STAT = 0
) (
    input  logic ijtag_tck,
    input  logic ijtag_reset,
    input  logic ijtag_sel,
    input  logic ijtag_ce,
    input  logic ijtag_se,
    input  logic prev_i,
    input  logic from_so_i,
    input  logic accept_i,
    output logic sib_o,
    output logic en_o
);

    logic sib_q;
    logic sib_d;
    logic lat_q;
    logic en_q;

    always_comb begin
        sib_d = sib_q;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sib_d = (CAPTURE_STAT != 0) ? lat_q : 1'b0;
            end else if (ijtag_se) begin
                sib_d = lat_q ? from_so_i : prev_i;
            end
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sib_q <= 1'b0;
        end else begin
            sib_q <= sib_d;
        end
    end

    // en samples lat before this edge's update, so the segment select lags by one tck.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            lat_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            en_q <= lat_q;
            if (accept_i) begin
                lat_q <= sib_q;
            end
        end
    end

    assign sib_o = sib_q;
    assign en_o  = en_q;

endmodule

// File: rtl/firebird7_ijtag_sib_multi.sv
// N-way SIB group: si -> [seg0] -> sib0 -> [seg1] -> sib1 ... -> sib[N-1] (-> par) -> so.
// Optional parity-protected update enabled by defining FIREBIRD7_SIB_MULTI_PARITY_EN.
module firebird7_ijtag_sib_multi
    import firebird7_ijtag_pkg::*;
#(
    parameter int NUM_SEG      = 4,
    parameter int EXCLUSIVE    = 0,
    parameter int CAPTURE_STAT = 0
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               ijtag_sel,
    input  logic               ijtag_ce,
    input  logic               ijtag_se,
    input  logic               ijtag_ue,
    input  logic               ijtag_si,
    output logic               ijtag_so,
    input  logic [NUM_SEG-1:0] ijtag_from_so,
    output logic [NUM_SEG-1:0] ijtag_to_si,
    output logic [NUM_SEG-1:0] ijtag_to_sel
);

    logic [NUM_SEG-1:0]         sib_w;
    logic [NUM_SEG-1:0]         en_w;
    logic [NUM_SEG-1:0]         prev_w;
    logic [FB7_SIB_MAX_SEG-1:0] sib_ext;
    logic                       excl_ok;
    logic                       rules_ok;
    logic                       accept_w;
    logic                       last_w;
    logic                       so_q;

    assign prev_w[0] = ijtag_si;

    for (genvar gi = 1; gi < NUM_SEG; gi++) begin : g_prev
        assign prev_w[gi] = sib_w[gi-1];
    end

    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_cell
        firebird7_ijtag_sib_cell #(
            .CAPTURE_STAT (CAPTURE_STAT)
        ) u_cell (
            .ijtag_tck   (ijtag_tck),
            .ijtag_reset (ijtag_reset),
            .ijtag_sel   (ijtag_sel),
            .ijtag_ce    (ijtag_ce),
            .ijtag_se    (ijtag_se),
            .prev_i      (prev_w[gi]),
            .from_so_i   (ijtag_from_so[gi]),
            .accept_i    (accept_w),
            .sib_o       (sib_w[gi]),
            .en_o        (en_w[gi])
        );
    end

    always_comb begin
        sib_ext = '0;
        sib_ext[NUM_SEG-1:0] = sib_w;
    end

    assign excl_ok = (EXCLUSIVE == 0) ? 1'b1 : fb7_onehot0(sib_ext);

`ifdef FIREBIRD7_SIB_MULTI_PARITY_EN
    logic par_q;
    logic par_d;
    logic err_q;

    always_comb begin
        par_d = par_q;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                par_d = err_q;
            end else if (ijtag_se) begin
                par_d = sib_w[NUM_SEG-1];
            end
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    // Sticky: any refused update is remembered until the next reset.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            err_q <= 1'b0;
        end else if (ijtag_ue && ijtag_sel && !rules_ok) begin
            err_q <= 1'b1;
        end
    end

    assign rules_ok = excl_ok && (^{sib_w, par_q});
    assign last_w   = par_q;
`else
    assign rules_ok = excl_ok;
    assign last_w   = sib_w[NUM_SEG-1];
`endif

    assign accept_w = ijtag_ue && ijtag_sel && rules_ok;

    // The chain tail only moves on posedge, so a negedge flop behaves exactly
    // like the low-transparent retiming latch while staying latch-free.
    always_ff @(negedge ijtag_tck) begin
        so_q <= last_w;
    end

    assign ijtag_so     = so_q;
    assign ijtag_to_si  = prev_w;
    assign ijtag_to_sel = en_w & {NUM_SEG{ijtag_sel}};

endmodule
